// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, redirect/stall/flush/halt control and IF/ID register.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] pc_o,
  input  logic [31:0] pc_plus4_i,
  input  logic [31:0] instr_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        halt_i,
  output logic [31:0] ifid_pc4_o,
  output logic [31:0] ifid_instr_o,
  output logic        ifid_valid_o,
  output logic        halted_o,
  output logic        misalign_o
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] bubble_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_d;
  logic [31:0] ifid_pc4_d;
  logic [31:0] ifid_instr_d;
  logic        ifid_valid_d;
  logic        misalign_d;

  logic        redirect;
  logic [31:0] target_raw;

  // Jump outranks branch, so the selected target (and its alignment) comes from jump first.
  assign redirect   = jump_i | branch_i;
  assign target_raw = jump_i ? jump_target_i : branch_target_i;

  // NOTE: every output of this block gets a default first so no path leaves a value
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_o;
    ifid_pc4_d   = ifid_pc4_o;
    ifid_instr_d = ifid_instr_o;
    ifid_valid_d = ifid_valid_o;
    misalign_d   = 1'b0;

    unique case (state_q)
      RST_HOLD: begin
        state_d      = RUN;
        pc_d         = RESET_PC;
        ifid_pc4_d   = pc_plus4_i;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end

      RUN: begin
        if (redirect) begin
          pc_d       = target_raw & ~32'h3;
          misalign_d = |target_raw[1:0];
        end else if (!stall_i) begin
          pc_d = pc_plus4_i;
        end

        if (flush_i || redirect) begin
          ifid_pc4_d   = pc_plus4_i;
          ifid_instr_d = NOP_INSTR;
          ifid_valid_d = 1'b0;
        end else if (!stall_i) begin
          ifid_pc4_d   = pc_plus4_i;
          ifid_instr_d = instr_i;
          ifid_valid_d = 1'b1;
        end

        if (halt_i && !stall_i) begin
          state_d = HALT;
        end
      end

      HALT: begin
        ifid_pc4_d   = pc_plus4_i;
        ifid_instr_d = NOP_INSTR;
        ifid_valid_d = 1'b0;
      end

      default: begin
        state_d = RST_HOLD;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= RST_HOLD;
      pc_o         <= RESET_PC;
      ifid_pc4_o   <= 32'h0;
      ifid_instr_o <= NOP_INSTR;
      ifid_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_o         <= pc_d;
      ifid_pc4_o   <= ifid_pc4_d;
      ifid_instr_o <= ifid_instr_d;
      ifid_valid_o <= ifid_valid_d;
      misalign_o   <= misalign_d;
    end
  end

  assign halted_o = (state_q == HALT);

`ifdef IF_PERF_CNT_EN
  logic fetch_evt;
  logic bubble_evt;

  // Only RUN counts; the RST_HOLD and HALT bubbles are not pipeline events.
  assign bubble_evt = (state_q == RUN) && (flush_i || redirect);
  assign fetch_evt  = (state_q == RUN) && !(flush_i || redirect) && !stall_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fetch_cnt_o  <= 32'h0;
      bubble_cnt_o <= 32'h0;
    end else begin
      if (fetch_evt)  fetch_cnt_o  <= fetch_cnt_o + 32'd1;
      if (bubble_evt) bubble_cnt_o <= bubble_cnt_o + 32'd1;
    end
  end
`else
  // Counters and their ports are absent in this build.
`endif

endmodule
